// File: rtl/uart_pkg.sv
// Shared UART definitions: default timing, payload width and transmit FSM states.
package uart_pkg;
    localparam int CLKS_PER_BIT_DEFAULT = 16;
    localparam int UART_DATA_BITS       = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// Modulo-CLKS_PER_BIT cycle counter; bit_done marks the last cycle of a bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          bit_done
);
    assign bit_done = (count == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear || bit_done)
            count <= '0;
        else
            count <= count + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register for gapless back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 sent,
    output logic                 bit_out
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    uart_tx_state_t       state, state_nx;
    logic [DATA_BITS-1:0] hold, shift, shift_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [CW-1:0]        count;
    logic                 bit_done, timer_clear, take, accept;
    logic                 hold_empty, bit_out_nx, sent_nx;

    // Timer is held at zero while idle so START always gets a full bit period.
    assign timer_clear = (state == IDLE);
    assign accept      = send && hold_empty;
    assign ready       = hold_empty;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .count    (count),
        .bit_done (bit_done)
    );

    always_comb begin
        state_nx = state;
        shift_nx = shift;
        idx_nx   = idx;
        take     = 1'b0;
        case (state)
            IDLE:  if (!hold_empty) begin
                       take     = 1'b1;
                       state_nx = START;
                   end
            START: if (bit_done) begin
                       state_nx = DATA;
                       idx_nx   = '0;
                   end
            DATA:  if (bit_done) begin
                       shift_nx = shift >> 1;
                       if (idx == IW'(DATA_BITS - 1))
                           state_nx = STOP;
                       else
                           idx_nx = idx + 1'b1;
                   end
            STOP:  if (bit_done) begin
                       if (!hold_empty) begin
                           take     = 1'b1;
                           state_nx = START;
                       end else begin
                           state_nx = IDLE;
                       end
                   end
            default: state_nx = IDLE;
        endcase
        if (take)
            shift_nx = hold;

        // Line level is computed for the next cycle so bit_out itself is a flop.
        case (state_nx)
            START:   bit_out_nx = 1'b0;
            DATA:    bit_out_nx = shift_nx[0];
            default: bit_out_nx = 1'b1;
        endcase
        sent_nx = (state == STOP) && (count == CW'(CLKS_PER_BIT - 2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            idx        <= '0;
            hold       <= '0;
            hold_empty <= 1'b1;
            bit_out    <= 1'b1;
            busy       <= 1'b0;
            sent       <= 1'b0;
        end else begin
            state   <= state_nx;
            shift   <= shift_nx;
            idx     <= idx_nx;
            bit_out <= bit_out_nx;
            busy    <= (state_nx != IDLE);
            sent    <= sent_nx;
            if (accept)
                hold <= data_in;
            // take and accept are exclusive: take needs a full register, accept an empty one.
            if (take)
                hold_empty <= 1'b1;
            else if (accept)
                hold_empty <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: cycle-exact line checks plus a mid-bit sampling receiver model.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       reset, send;
    logic [7:0] data_in;
    logic       ready, busy, sent, bit_out;

    int         n_cmp = 0, n_err = 0, n_sent = 0, mcnt = -1;
    logic [7:0] mbyte;
    logic       mferr;
    logic [8:0] mon_q[$];

    uart_tx dut (
        .clk     (clk),
        .reset   (reset),
        .send    (send),
        .data_in (data_in),
        .ready   (ready),
        .busy    (busy),
        .sent    (sent),
        .bit_out (bit_out)
    );

    always #5 clk = ~clk;

    // Receiver model: start detected on first low sample, then sampled mid-bit.
    always @(negedge clk) begin
        if (reset) begin
            mcnt = -1;
        end else begin
            if (sent === 1'b1) n_sent++;
            if (mcnt < 0) begin
                if (bit_out === 1'b0) begin
                    mcnt = 0; mbyte = '0; mferr = 1'b0;
                end
            end else begin
                mcnt++;
                if (mcnt == 8 && bit_out !== 1'b0) mferr = 1'b1;
                if (mcnt >= 24 && mcnt <= 136 && ((mcnt - 8) % 16) == 0)
                    mbyte[(mcnt - 24) / 16] = bit_out;
                if (mcnt == 152) begin
                    if (bit_out !== 1'b1) mferr = 1'b1;
                    mon_q.push_back({mferr, mbyte});
                    mcnt = -1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic exp_line(input logic [7:0] b, input int k);
        int slot;
        slot = k / 16;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Leaves the bench in cycle E+1 (the one right after the accepting edge).
    task automatic send_byte(input logic [7:0] b, input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 400) begin step(); n++; end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++; $display("FAIL %s ready_timeout: ready=%b want 1", name, ready);
        end
        send = 1'b1; data_in = b;
        step();
        send = 1'b0;
        n_cmp++;
        if ({ready, busy, bit_out} !== 3'b001) begin
            n_err++; $display("FAIL %s accept: ready/busy/bit_out=%b want 001", name, {ready, busy, bit_out});
        end
    endtask

    task automatic check_frame(input logic [7:0] b, input int k0, input bit scramble, input string name);
        logic [2:0] e;
        for (int k = k0; k < 160; k++) begin
            e = {exp_line(b, k), 1'b1, (k == 159)};
            n_cmp++;
            if ({bit_out, busy, sent} !== e) begin
                n_err++;
                $display("FAIL %s k=%0d bit_out/busy/sent=%b want %b", name, k, {bit_out, busy, sent}, e);
            end
            if (scramble) data_in = 8'($urandom);
            step();
        end
    endtask

    task automatic wait_idle(input int max, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin step(); n++; end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL %s idle_timeout: busy=%b want 0", name, busy);
        end
    endtask

    task automatic check_rx(input logic [7:0] b, input int idx, input string name);
        n_cmp++;
        if (mon_q.size() <= idx) begin
            n_err++; $display("FAIL %s rx[%0d]: got nothing want %h", name, idx, b);
        end else if (mon_q[idx] !== {1'b0, b}) begin
            n_err++; $display("FAIL %s rx[%0d]: ferr/byte=%h want 0/%h", name, idx, mon_q[idx], b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; send = 1'b0; data_in = '0;
        repeat (3) step();
        n_cmp++;
        if ({bit_out, ready, busy, sent} !== 4'b1100) begin
            n_err++; $display("FAIL reset_hold: bit_out/ready/busy/sent=%b want 1100", {bit_out, ready, busy, sent});
        end
        reset = 1'b0;
        repeat (2) step();
        n_cmp++;
        if ({bit_out, ready, busy, sent} !== 4'b1100) begin
            n_err++; $display("FAIL reset_release: bit_out/ready/busy/sent=%b want 1100", {bit_out, ready, busy, sent});
        end
    endtask

    task automatic test_single_a5();
        int s0;
        mon_q.delete(); s0 = n_sent;
        send_byte(8'hA5, "a5");
        step();
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++; $display("FAIL a5_ready_at_start: ready=%b want 1", ready);
        end
        check_frame(8'hA5, 0, 1'b0, "a5");
        n_cmp++;
        if ({bit_out, busy} !== 2'b10) begin
            n_err++; $display("FAIL a5_after: bit_out/busy=%b want 10", {bit_out, busy});
        end
        n_cmp++;
        if (n_sent - s0 != 1) begin
            n_err++; $display("FAIL a5_sent_count: got %0d want 1", n_sent - s0);
        end
        check_rx(8'hA5, 0, "a5");
    endtask

    task automatic test_loopback();
        logic [7:0] vec [3];
        int s0;
        vec = '{8'h00, 8'hFF, 8'h55};
        foreach (vec[i]) begin
            mon_q.delete(); s0 = n_sent;
            send_byte(vec[i], "loop");
            step();
            wait_idle(200, "loop");
            step();
            check_rx(vec[i], 0, "loop");
            n_cmp++;
            if (n_sent - s0 != 1 || mon_q.size() != 1) begin
                n_err++; $display("FAIL loop_once %h: sent=%0d frames=%0d want 1/1", vec[i], n_sent - s0, mon_q.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        mon_q.delete();
        send_byte(8'h31, "b2b");
        step();
        send = 1'b1; data_in = 8'h32;
        step();
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_held: ready=%b want 0", ready);
        end
        data_in = 8'h33;
        step();
        send = 1'b0;
        check_frame(8'h31, 2, 1'b0, "b2b_first");
        check_frame(8'h32, 0, 1'b0, "b2b_second");
        n_cmp++;
        if ({busy, ready, bit_out} !== 3'b011) begin
            n_err++; $display("FAIL b2b_end: busy/ready/bit_out=%b want 011", {busy, ready, bit_out});
        end
        step();
        check_rx(8'h31, 0, "b2b");
        check_rx(8'h32, 1, "b2b");
        n_cmp++;
        if (mon_q.size() != 2) begin
            n_err++; $display("FAIL b2b_frames: got %0d want 2", mon_q.size());
        end
    endtask

    // Accepting edges from idle with send held: slots 0, 2, 162, 322.
    task automatic test_continuous();
        logic [7:0] expv [4];
        expv = '{8'h03, 8'h11, 8'h71, 8'hD1};
        mon_q.delete();
        send = 1'b1;
        for (int j = 0; j < 400; j++) begin
            data_in = 8'(j * 7 + 3);
            step();
        end
        send = 1'b0;
        wait_idle(400, "cont");
        step();
        n_cmp++;
        if (mon_q.size() != 4) begin
            n_err++; $display("FAIL cont_frames: got %0d want 4", mon_q.size());
        end
        foreach (expv[i]) check_rx(expv[i], i, "cont");
    endtask

    task automatic test_reset_midframe();
        int s0;
        mon_q.delete();
        send_byte(8'hC3, "rst");
        step();
        send = 1'b1; data_in = 8'h3C;
        step();
        send = 1'b0;
        repeat (69) step();
        n_cmp++;
        if (bit_out !== 1'b0) begin
            n_err++; $display("FAIL rst_pre: bit_out=%b want 0", bit_out);
        end
        s0 = n_sent;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bit_out, busy, ready, sent} !== 4'b1010) begin
            n_err++; $display("FAIL rst_async: bit_out/busy/ready/sent=%b want 1010", {bit_out, busy, ready, sent});
        end
        step();
        reset = 1'b0;
        repeat (200) step();
        n_cmp++;
        if (n_sent != s0 || mon_q.size() != 0 || {busy, bit_out} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_discard: sent=%0d frames=%0d busy/bit_out=%b want 0/0/01", n_sent - s0, mon_q.size(), {busy, bit_out});
        end
        send_byte(8'h96, "rst_after");
        step();
        check_frame(8'h96, 0, 1'b0, "rst_after");
        step();
        check_rx(8'h96, 0, "rst_after");
    endtask

    task automatic test_data_change();
        mon_q.delete();
        send_byte(8'h5A, "dchg");
        step();
        check_frame(8'h5A, 0, 1'b1, "dchg");
        step();
        check_rx(8'h5A, 0, "dchg");
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_loopback();
        test_back_to_back();
        test_continuous();
        test_reset_midframe();
        test_data_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
